// File: rtl/mipi_readback_ctrl_pkg.sv
// Shared definitions for the DSI readback controller:
// FSM encodings, header field positions, error bit indices.
package mipi_readback_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;
    localparam logic [1:0] ST_PAY  = 2'd3;

    localparam int HDR_DT_LO = 0;
    localparam int HDR_DT_HI = 5;
    localparam int HDR_VC_LO = 6;
    localparam int HDR_VC_HI = 7;
    localparam int HDR_WC_LO = 8;
    localparam int HDR_WC_HI = 23;

    localparam int ERR_NODATA = 0;
    localparam int ERR_TMO    = 1;
    localparam int ERR_ABORT  = 2;
    localparam int ERR_LEN    = 3;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] bc;
    } cmd_t;

    // ceil(bc / 2**sh) in 17-bit arithmetic so 0xFFFF does not wrap
    function automatic logic [15:0] words_for(input logic [15:0] bc, input int sh);
        logic [16:0] s;
        s = {1'b0, bc} + 17'((1 << sh) - 1);
        return 16'(s >> sh);
    endfunction

endpackage

// File: rtl/mipi_readback_ctrl_len_chk.sv
// Payload length checker: expected word count, word counter,
// and the final count-vs-expected compare.
module mipi_rb_len_chk
    import mipi_readback_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [15:0] byte_count,
    input  logic        inc,
    output logic        exp_zero,
    output logic        len_bad
);

    localparam int SH = $clog2(DATA_W / 8);

    logic [15:0] exp_words;
    logic [15:0] cnt;

    // latch expected words with the header; count consumed payload words
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_words <= '0;
            cnt       <= '0;
        end else if (load) begin
            exp_words <= words_for(byte_count, SH);
            cnt       <= '0;
        end else if (inc) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign exp_zero = (exp_words == 16'd0);
    assign len_bad  = ((cnt + 16'd1) != exp_words);

endmodule

// File: rtl/mipi_readback_ctrl.sv
// Peripheral-side DSI read-response controller: pops a header
// on bus turnaround, issues one TX command, streams the payload.
module mipi_readback_ctrl
    import mipi_readback_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 2,
    parameter int ACK_TMO = 1023,
    parameter int VC_HDR  = 1
) (
    input  logic              clk_periph,
    input  logic              rstn,
    input  logic              mipi_periph_dphy_direction,
    input  logic              mipi_periph_tx_cmd_ack,
    input  logic              mipi_periph_tx_payload_en,
    input  logic              mipi_periph_tx_payload_en_last,
    output logic              bta_clk,
    output logic              bta_rd,
    input  logic [DATA_W-1:0] bta_data,
    input  logic              bta_empty,
    output logic [DATA_W-1:0] mipi_periph_tx_payload,
    output logic [1:0]        mipi_periph_tx_cmd_vc,
    output logic [5:0]        mipi_periph_tx_cmd_data_type,
    output logic [15:0]       mipi_periph_tx_cmd_byte_count,
    output logic              mipi_periph_tx_cmd_req,
    output logic              busy,
    output logic [3:0]        err_flags,
    input  logic              err_clr
);

    localparam logic [2:0]  LAT_LAST = 3'(RD_LAT - 1);
    localparam logic [15:0] TMO_LAST = 16'(ACK_TMO - 1);

    logic        dir_d;
    logic        fall;
    logic        rise;
    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [2:0]  lat_cnt;
    logic [15:0] tmo_cnt;
    logic        hdr_done;
    logic        tmo_hit;
    logic        pay_word;
    logic        pay_last;
    logic        exp_zero;
    logic        len_bad;
    logic [3:0]  err_set;
    cmd_t        cmd;

    assign fall     = dir_d & ~mipi_periph_dphy_direction;
    assign rise     = ~dir_d & mipi_periph_dphy_direction;
    assign hdr_done = (state == ST_HDR) && (lat_cnt == LAT_LAST);
    assign tmo_hit  = (ACK_TMO != 0) && (tmo_cnt == TMO_LAST);
    assign pay_word = (state == ST_PAY) && mipi_periph_tx_payload_en;
    assign pay_last = pay_word && mipi_periph_tx_payload_en_last;

    assign bta_clk = clk_periph;
    assign bta_rd  = ((state == ST_IDLE) && fall && !bta_empty) || pay_word;

    assign mipi_periph_tx_payload        = bta_data;
    assign mipi_periph_tx_cmd_vc         = cmd.vc;
    assign mipi_periph_tx_cmd_data_type  = cmd.dt;
    assign mipi_periph_tx_cmd_byte_count = cmd.bc;
    assign mipi_periph_tx_cmd_req        = (state == ST_REQ);
    assign busy                          = (state != ST_IDLE);

    mipi_rb_len_chk #(
        .DATA_W (DATA_W)
    ) u_len_chk (
        .clk        (clk_periph),
        .rstn       (rstn),
        .load       (hdr_done),
        .byte_count (bta_data[HDR_WC_HI:HDR_WC_LO]),
        .inc        (pay_word),
        .exp_zero   (exp_zero),
        .len_bad    (len_bad)
    );

    // next state and error events; abort beats ack and last
    always_comb begin
        state_n = state;
        err_set = '0;
        unique case (state)
            ST_IDLE: begin
                if (fall) begin
                    if (bta_empty) err_set[ERR_NODATA] = 1'b1;
                    else           state_n = ST_HDR;
                end
            end
            ST_HDR: begin
                if (rise) begin
                    err_set[ERR_ABORT] = 1'b1;
                    state_n = ST_IDLE;
                end else if (hdr_done) begin
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rise) begin
                    err_set[ERR_ABORT] = 1'b1;
                    state_n = ST_IDLE;
                end else if (mipi_periph_tx_cmd_ack) begin
                    state_n = exp_zero ? ST_IDLE : ST_PAY;
                end else if (tmo_hit) begin
                    err_set[ERR_TMO] = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_PAY: begin
                if (rise) begin
                    err_set[ERR_ABORT] = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    if (pay_word && bta_empty) err_set[ERR_NODATA] = 1'b1;
                    if (pay_last) begin
                        if (len_bad) err_set[ERR_LEN] = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // state, direction history, latency and timeout counters
    always_ff @(posedge clk_periph or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            dir_d   <= 1'b0;
            lat_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_n;
            dir_d   <= mipi_periph_dphy_direction;
            lat_cnt <= (state == ST_HDR) ? lat_cnt + 3'd1 : 3'd0;
            tmo_cnt <= (state == ST_REQ) ? tmo_cnt + 16'd1 : 16'd0;
        end
    end

    // command fields captured when the header word is valid
    always_ff @(posedge clk_periph or negedge rstn) begin
        if (!rstn) begin
            cmd <= '0;
        end else if (hdr_done) begin
            cmd.dt <= bta_data[HDR_DT_HI:HDR_DT_LO];
            cmd.bc <= bta_data[HDR_WC_HI:HDR_WC_LO];
            cmd.vc <= (VC_HDR != 0) ? bta_data[HDR_VC_HI:HDR_VC_LO] : 2'd0;
        end
    end

    // sticky error flags; a new event wins over a same-cycle clear
    always_ff @(posedge clk_periph or negedge rstn) begin
        if (!rstn) err_flags <= '0;
        else       err_flags <= (err_flags & ~{4{err_clr}}) | err_set;
    end

endmodule

// File: tb/tb_mipi_readback_ctrl.sv
// Directed bench for mipi_readback_ctrl: table-driven transactions
// on a 32-bit instance plus corner sequences and a 64-bit instance.
module tb_mipi_readback_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dir;
    logic        dir64;
    logic        ack;
    logic        pay_en;
    logic        pay_last;
    logic        empty;
    logic        err_clr;
    logic [31:0] data32;
    logic [63:0] data64;

    logic        bclk32, rd32, req32, busy32;
    logic [31:0] pay32;
    logic [1:0]  vc32;
    logic [5:0]  dt32;
    logic [15:0] bc32;
    logic [3:0]  err32;

    logic        bclk64, rd64, req64, busy64;
    logic [63:0] pay64;
    logic [1:0]  vc64;
    logic [5:0]  dt64;
    logic [15:0] bc64;
    logic [3:0]  err64;

    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt = 0;

    always #5 clk = ~clk;

    mipi_readback_ctrl #(
        .DATA_W(32), .RD_LAT(2), .ACK_TMO(8), .VC_HDR(1)
    ) dut (
        .clk_periph                     (clk),
        .rstn                           (rst_n),
        .mipi_periph_dphy_direction     (dir),
        .mipi_periph_tx_cmd_ack         (ack),
        .mipi_periph_tx_payload_en      (pay_en),
        .mipi_periph_tx_payload_en_last (pay_last),
        .bta_clk                        (bclk32),
        .bta_rd                         (rd32),
        .bta_data                       (data32),
        .bta_empty                      (empty),
        .mipi_periph_tx_payload         (pay32),
        .mipi_periph_tx_cmd_vc          (vc32),
        .mipi_periph_tx_cmd_data_type   (dt32),
        .mipi_periph_tx_cmd_byte_count  (bc32),
        .mipi_periph_tx_cmd_req         (req32),
        .busy                           (busy32),
        .err_flags                      (err32),
        .err_clr                        (err_clr)
    );

    mipi_readback_ctrl #(
        .DATA_W(64), .RD_LAT(2), .ACK_TMO(1023), .VC_HDR(1)
    ) dut64 (
        .clk_periph                     (clk),
        .rstn                           (rst_n),
        .mipi_periph_dphy_direction     (dir64),
        .mipi_periph_tx_cmd_ack         (ack),
        .mipi_periph_tx_payload_en      (pay_en),
        .mipi_periph_tx_payload_en_last (pay_last),
        .bta_clk                        (bclk64),
        .bta_rd                         (rd64),
        .bta_data                       (data64),
        .bta_empty                      (empty),
        .mipi_periph_tx_payload         (pay64),
        .mipi_periph_tx_cmd_vc          (vc64),
        .mipi_periph_tx_cmd_data_type   (dt64),
        .mipi_periph_tx_cmd_byte_count  (bc64),
        .mipi_periph_tx_cmd_req         (req64),
        .busy                           (busy64),
        .err_flags                      (err64),
        .err_clr                        (err_clr)
    );

    // count FIFO pops of the 32-bit instance
    always @(posedge clk) if (rd32) rd_cnt <= rd_cnt + 1;

    typedef struct {
        logic [31:0] hdr;
        int          words;
        logic [5:0]  dt;
        logic [1:0]  vc;
        logic [15:0] bc;
        logic [3:0]  err;
    } vec_t;

    vec_t tbl [5];

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_errs;
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
    endtask

    // full read response on the 32-bit instance, ack on first req cycle
    task automatic run32(input vec_t v, input int idx);
        int start;
        int lat;
        start = rd_cnt;
        data32 = v.hdr;
        empty = 1'b0;
        dir = 1'b0;
        #1;
        chk($sformatf("v%0d rd_at_fall", idx), 32'(rd32), 32'd1);
        lat = 0;
        while (!req32 && lat < 20) begin
            tick;
            lat++;
            #1;
        end
        chk($sformatf("v%0d req_lat", idx), 32'(lat), 32'd3);
        ack = 1'b1;
        tick;
        ack = 1'b0;
        #1;
        chk($sformatf("v%0d req_drop", idx), 32'(req32), 32'd0);
        for (int i = 0; i < v.words; i++) begin
            pay_en = 1'b1;
            pay_last = (i == v.words - 1);
            tick;
        end
        pay_en = 1'b0;
        pay_last = 1'b0;
        dir = 1'b1;
        tick;
        #1;
        chk($sformatf("v%0d dt", idx), 32'(dt32), 32'(v.dt));
        chk($sformatf("v%0d vc", idx), 32'(vc32), 32'(v.vc));
        chk($sformatf("v%0d bc", idx), 32'(bc32), 32'(v.bc));
        chk($sformatf("v%0d err", idx), 32'(err32), 32'(v.err));
        chk($sformatf("v%0d busy", idx), 32'(busy32), 32'd0);
        chk($sformatf("v%0d pops", idx), 32'(rd_cnt - start), 32'(1 + v.words));
    endtask

    initial begin
        int hi;
        int lat;

        tbl[0] = '{32'h0000_0C1A, 3, 6'h1A, 2'd0, 16'd12, 4'b0000};
        tbl[1] = '{32'h0000_0002, 0, 6'h02, 2'd0, 16'd0,  4'b0000};
        tbl[2] = '{32'h0000_05C9, 2, 6'h09, 2'd3, 16'd5,  4'b0000};
        tbl[3] = '{32'h0000_0729, 1, 6'h29, 2'd0, 16'd7,  4'b1000};
        tbl[4] = '{32'hFF00_103E, 4, 6'h3E, 2'd0, 16'd16, 4'b0000};

        rst_n = 1'b0;
        dir = 1'b1;
        dir64 = 1'b1;
        ack = 1'b0;
        pay_en = 1'b0;
        pay_last = 1'b0;
        empty = 1'b0;
        err_clr = 1'b0;
        data32 = '0;
        data64 = '0;
        tick;
        tick;
        #1;
        chk("rst req", 32'(req32), 32'd0);
        chk("rst busy", 32'(busy32), 32'd0);
        chk("rst err", 32'(err32), 32'd0);
        chk("rst rd", 32'(rd32), 32'd0);
        chk("rst cmd", {8'd0, vc32, dt32, bc32}, 32'd0);
        rst_n = 1'b1;
        tick;
        tick;

        foreach (tbl[i]) begin
            clear_errs;
            run32(tbl[i], i);
        end

        // empty FIFO at turnaround
        clear_errs;
        empty = 1'b1;
        dir = 1'b0;
        #1;
        chk("nodata rd", 32'(rd32), 32'd0);
        tick;
        dir = 1'b1;
        #1;
        chk("nodata err", 32'(err32), 32'd1);
        chk("nodata busy", 32'(busy32), 32'd0);
        tick;
        tick;
        #1;
        chk("nodata req", 32'(req32), 32'd0);
        clear_errs;
        #1;
        chk("err_clr", 32'(err32), 32'd0);
        empty = 1'b0;

        // ack timeout
        data32 = 32'h0000_0C1A;
        dir = 1'b0;
        lat = 0;
        while (!req32 && lat < 20) begin
            tick;
            lat++;
            #1;
        end
        hi = 0;
        while (req32 && hi < 50) begin
            hi++;
            tick;
            #1;
        end
        chk("tmo req_cycles", 32'(hi), 32'd8);
        chk("tmo err", 32'(err32), 32'b0010);
        chk("tmo busy", 32'(busy32), 32'd0);
        dir = 1'b1;
        tick;
        clear_errs;

        // abort on the same cycle as a short last
        data32 = 32'h0000_0C1A;
        dir = 1'b0;
        lat = 0;
        while (!req32 && lat < 20) begin
            tick;
            lat++;
            #1;
        end
        ack = 1'b1;
        tick;
        ack = 1'b0;
        pay_en = 1'b1;
        pay_last = 1'b0;
        tick;
        pay_last = 1'b1;
        dir = 1'b1;
        tick;
        pay_en = 1'b0;
        pay_last = 1'b0;
        #1;
        chk("abort err", 32'(err32), 32'b0100);
        chk("abort busy", 32'(busy32), 32'd0);
        clear_errs;

        // reset mid-transfer
        dir = 1'b0;
        tick;
        tick;
        #1;
        chk("mid busy pre", 32'(busy32), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", 32'(busy32), 32'd0);
        chk("mid rst req", 32'(req32), 32'd0);
        tick;
        rst_n = 1'b1;
        dir = 1'b1;
        tick;
        tick;

        // 64-bit instance: wc 10 -> 2 words, core sends 3
        data64 = 64'h0000_0000_0000_0A80;
        dir64 = 1'b0;
        lat = 0;
        while (!req64 && lat < 20) begin
            tick;
            lat++;
            #1;
        end
        chk("w64 req_lat", 32'(lat), 32'd3);
        ack = 1'b1;
        tick;
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pay_en = 1'b1;
            pay_last = (i == 2);
            tick;
        end
        pay_en = 1'b0;
        pay_last = 1'b0;
        dir64 = 1'b1;
        tick;
        #1;
        chk("w64 err", 32'(err64), 32'b1000);
        chk("w64 vc", 32'(vc64), 32'd2);
        chk("w64 bc", 32'(bc64), 32'd10);
        chk("w64 dt", 32'(dt64), 32'd0);
        chk("w64 busy", 32'(busy64), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
